alu_step_ctrl: RTL and testbench

//  Button-driven sequencer for the operand-register / ALU / result-register datapath.

---
 rtl/alu_step_ctrl_if.sv | 27 ++
 rtl/alu_step_ctrl.sv | 150 +++++++++++++++
 tb/tb_alu_step_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_step_ctrl_if.sv
// Board-side bundle for the step controller: raw buttons and the accumulate
// switch in, register enables and status out.
interface alu_step_ctrl_if #(
    parameter int CW = 8
);
    logic          btn_load;
    logic          btn_exec;
    logic          acc_mode;
    logic          en_a;
    logic          a_sel;
    logic          en_r;
    logic          busy;
    logic          have_a;
    logic [CW-1:0] op_count;

    // Board / stimulus side: drives buttons, observes enables.
    modport master (
        output btn_load, btn_exec, acc_mode,
        input  en_a, a_sel, en_r, busy, have_a, op_count
    );

    // Controller side.
    modport slave (
        input  btn_load, btn_exec, acc_mode,
        output en_a, a_sel, en_r, busy, have_a, op_count
    );
endinterface

// File: rtl/alu_step_ctrl.sv
// Button-driven sequencer for the operand-A / ALU / result-register datapath.
// Each raw button goes through its own synchroniser + debouncer lane, which
// emits a single-cycle press pulse. A Moore FSM turns those pulses into
// one-cycle register enables, with an optional write-back of the result
// into operand A (accumulate mode).

// One debounced button lane: 2-FF synchroniser, stability counter, rising
// pulse on the cycle the new level is accepted.
module alu_step_ctrl_db #(
    parameter int DB_COUNT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CNT_W = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Synchronise, then accept a new level only after DB_COUNT differing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            pulse <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Release is accepted silently; only a press produces a pulse.
                stable <= s2;
                pulse  <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module alu_step_ctrl #(
    parameter int N        = 8,
    parameter int DB_COUNT = 1000000,
    parameter int CW       = 8
) (
    input logic           clk,
    input logic           rst,
    alu_step_ctrl_if.slave bus
);
    // Lane 0 = load button, lane 1 = exec button.
    localparam int NUM_BTN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_HAVE_A,
        S_EXEC,
        S_WB_A
    } state_t;

    // N only sizes the external datapath; reject nonsense widths early.
    if (N < 1 || CW < 1 || DB_COUNT < 1) begin : g_bad_param
        $error("alu_step_ctrl: N, CW and DB_COUNT must all be >= 1");
    end

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_edge;
    logic               ld;
    logic               ex;

    state_t        state;
    state_t        state_n;
    logic          en_a;
    logic          a_sel;
    logic          en_r;
    logic          busy;
    logic          have_a;
    logic [CW-1:0] op_count;

    assign btn_raw = {bus.btn_exec, bus.btn_load};
    assign ld      = btn_edge[0];
    assign ex      = btn_edge[1];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        alu_step_ctrl_db #(
            .DB_COUNT(DB_COUNT)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .pulse(btn_edge[i])
        );
    end

    // Next-state logic. Pulses arriving in the transient states are dropped.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (ld) state_n = S_LOAD_A;
            S_LOAD_A: state_n = S_HAVE_A;
            S_HAVE_A: begin
                // Load has priority; a simultaneous exec is discarded.
                if (ld)      state_n = S_LOAD_A;
                else if (ex) state_n = S_EXEC;
            end
            S_EXEC:   state_n = bus.acc_mode ? S_WB_A : S_HAVE_A;
            S_WB_A:   state_n = S_HAVE_A;
            default:  state_n = S_IDLE;
        endcase
    end

    // State and Moore outputs registered together, so each enable is high
    // exactly during the cycle its state is occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            en_a     <= 1'b0;
            a_sel    <= 1'b0;
            en_r     <= 1'b0;
            busy     <= 1'b0;
            have_a   <= 1'b0;
            op_count <= '0;
        end else begin
            state  <= state_n;
            en_a   <= (state_n == S_LOAD_A) || (state_n == S_WB_A);
            a_sel  <= (state_n == S_WB_A);
            en_r   <= (state_n == S_EXEC);
            busy   <= (state_n == S_EXEC) || (state_n == S_WB_A);
            have_a <= (state_n != S_IDLE);
            if (state_n == S_EXEC) op_count <= op_count + CW'(1);
        end
    end

    assign bus.en_a     = en_a;
    assign bus.a_sel    = a_sel;
    assign bus.en_r     = en_r;
    assign bus.busy     = busy;
    assign bus.have_a   = have_a;
    assign bus.op_count = op_count;
endmodule

// File: tb/tb_alu_step_ctrl.sv
// Bench for alu_step_ctrl with DB_COUNT=4. Every cycle in which an enable or
// busy is high is packed into an event word and matched against the head of
// an expected-event queue filled when the stimulus is driven.
module tb_alu_step_ctrl;
    localparam int CW = 8;
    localparam int DB = 4;
    // Press driven at cycle c -> enable visible c+7 (2 sync + DB + 1 FSM).
    localparam int LAT = DB + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] sb[$];

    alu_step_ctrl_if #(.CW(CW)) bus ();

    alu_step_ctrl #(.N(8), .DB_COUNT(DB), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ev(input int c, input bit b, input bit ea,
                                       input bit er, input bit as);
        return {c[27:0], b, ea, er, as};
    endfunction

    // Compare every active-output cycle against the expected queue.
    always @(negedge clk) begin
        if (bus.busy === 1'b1 || bus.en_a === 1'b1 || bus.en_r === 1'b1) begin
            logic [31:0] w;
            w = ev(cyc, bus.busy, bus.en_a, bus.en_r, bus.a_sel);
            if (sb.size() == 0) chk("sb_spurious", w, 32'h0);
            else                chk("sb_event", w, sb.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit is_exec, input int hold, input int rel);
        if (is_exec) bus.btn_exec = 1'b1; else bus.btn_load = 1'b1;
        tick(hold);
        if (is_exec) bus.btn_exec = 1'b0; else bus.btn_load = 1'b0;
        tick(rel);
    endtask

    initial begin
        int c;
        bus.btn_load = 1'b0;
        bus.btn_exec = 1'b0;
        bus.acc_mode = 1'b0;

        // Reset state
        tick(3);
        chk("rst_outs", {27'd0, bus.en_a, bus.en_r, bus.a_sel, bus.busy, bus.have_a}, 32'd0);
        chk("rst_cnt", 32'(bus.op_count), 32'd0);
        rst = 1'b0;
        tick(2);

        // Exec while IDLE is ignored
        press(1'b1, 10, 10);
        chk("idle_ex_cnt", 32'(bus.op_count), 32'd0);
        chk("idle_ex_have", 32'(bus.have_a), 32'd0);

        // Held load -> single en_a, a_sel=0
        c = cyc; sb.push_back(ev(c + LAT, 0, 1, 0, 0));
        press(1'b0, 10, 10);
        chk("load_have", 32'(bus.have_a), 32'd1);

        // Exec, no accumulate
        c = cyc; sb.push_back(ev(c + LAT, 1, 0, 1, 0));
        press(1'b1, 8, 10);
        chk("ex_cnt1", 32'(bus.op_count), 32'd1);

        // Exec with accumulate: en_r then write-back
        bus.acc_mode = 1'b1;
        c = cyc;
        sb.push_back(ev(c + LAT, 1, 0, 1, 0));
        sb.push_back(ev(c + LAT + 1, 1, 1, 0, 1));
        press(1'b1, 8, 10);
        chk("acc_cnt2", 32'(bus.op_count), 32'd2);
        bus.acc_mode = 1'b0;

        // Load and exec together: load wins
        c = cyc; sb.push_back(ev(c + LAT, 0, 1, 0, 0));
        bus.btn_load = 1'b1; bus.btn_exec = 1'b1;
        tick(10);
        bus.btn_load = 1'b0; bus.btn_exec = 1'b0;
        tick(10);
        chk("both_cnt", 32'(bus.op_count), 32'd2);

        // 1-cycle bounce on both buttons: nothing
        for (int i = 0; i < 20; i++) begin
            bus.btn_exec = ~bus.btn_exec;
            bus.btn_load = ~bus.btn_load;
            tick(1);
        end
        bus.btn_exec = 1'b0; bus.btn_load = 1'b0;
        tick(10);
        chk("bounce_cnt", 32'(bus.op_count), 32'd2);

        // Glitch one cycle shorter than DB_COUNT: nothing
        press(1'b1, DB - 1, 10);
        chk("glitch_cnt", 32'(bus.op_count), 32'd2);

        // Exactly DB_COUNT cycles is accepted
        c = cyc; sb.push_back(ev(c + LAT, 0, 1, 0, 0));
        press(1'b0, DB, 10);

        // Counter wrap
        for (int i = 0; i < 253; i++) begin
            c = cyc; sb.push_back(ev(c + LAT, 1, 0, 1, 0));
            press(1'b1, 8, 8);
        end
        chk("cnt_255", 32'(bus.op_count), 32'd255);
        c = cyc; sb.push_back(ev(c + LAT, 1, 0, 1, 0));
        press(1'b1, 8, 8);
        chk("cnt_wrap", 32'(bus.op_count), 32'd0);

        // Reset during WB_A
        bus.acc_mode = 1'b1;
        c = cyc;
        sb.push_back(ev(c + LAT, 1, 0, 1, 0));
        sb.push_back(ev(c + LAT + 1, 1, 1, 0, 1));
        bus.btn_exec = 1'b1;
        tick(LAT + 1);
        rst = 1'b1;
        tick(1);
        chk("wb_rst_outs", {27'd0, bus.en_a, bus.en_r, bus.a_sel, bus.busy, bus.have_a}, 32'd0);
        chk("wb_rst_cnt", 32'(bus.op_count), 32'd0);
        rst = 1'b0;
        // Still-held exec re-debounces into IDLE and is ignored
        tick(12);
        bus.btn_exec = 1'b0;
        bus.acc_mode = 1'b0;
        tick(12);
        chk("post_rst_cnt", 32'(bus.op_count), 32'd0);
        chk("post_rst_have", 32'(bus.have_a), 32'd0);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
